ahb_bus_arbiter: RTL and testbench



---
 rtl/ahb_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahb_bus_arbiter
// Brief   : Round-robin AHB arbiter for the AHB-to-APB bridge slave port.
//           Re-arbitrates only at burst boundaries. Locked transfers are
//           honoured when AHB_ARB_LOCK_EN is defined.
// Revision: 1.0
// ============================================================================
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int IDX_W          = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [IDX_W-1:0]       HMASTER,
  output logic [IDX_W-1:0]       HMASTER_DP,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] c_trans_idle   = 2'b00;
  localparam logic [1:0] c_trans_busy   = 2'b01;
  localparam logic [1:0] c_trans_nonseq = 2'b10;
  localparam logic [1:0] c_trans_seq    = 2'b11;

  localparam logic [1:0] c_st_park   = 2'd0;
  localparam logic [1:0] c_st_own    = 2'd1;
  localparam logic [1:0] c_st_burst  = 2'd2;
`ifdef AHB_ARB_LOCK_EN
  localparam logic [1:0] c_st_locked = 2'd3;
`endif

  localparam logic [IDX_W-1:0]       c_default_idx   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_default_grant = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [IDX_W-1:0]       r_hmaster;
  logic [IDX_W-1:0]       r_hmaster_dp;
  logic                   r_hmastlock;

  logic                   w_locked;
  logic                   w_owner_lock;
  logic                   w_lock_ok;
  logic                   w_lock_take;
  logic                   w_arb_ok;
  logic                   w_any_req;
  logic                   w_found;
  logic [IDX_W-1:0]       w_scan;
  logic [IDX_W-1:0]       w_winner;
  logic [NUM_MASTERS-1:0] w_winner_oh;

  // Remaining beats after the one on the bus this cycle.
  always_comb begin : p_cnt_next
    w_cnt_next = r_cnt;
    case (HTRANS)
      c_trans_idle:   w_cnt_next = 4'd0;
      c_trans_busy:   w_cnt_next = r_cnt;
      c_trans_nonseq: begin
        case (HBURST)
          3'd2, 3'd3: w_cnt_next = 4'd3;
          3'd4, 3'd5: w_cnt_next = 4'd7;
          3'd6, 3'd7: w_cnt_next = 4'd15;
          default:    w_cnt_next = 4'd0;
        endcase
      end
      c_trans_seq:    w_cnt_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
      default:        w_cnt_next = r_cnt;
    endcase
  end

`ifdef AHB_ARB_LOCK_EN
  logic w_unlock;
  assign w_owner_lock = HLOCK[r_owner];
  assign w_unlock     = w_locked && HREADY && !w_owner_lock && (HTRANS == c_trans_idle);
  assign w_lock_ok    = !w_locked || w_unlock;
`else
  logic w_unused_hlock;
  assign w_unused_hlock = |HLOCK;
  assign w_owner_lock   = 1'b0;
  assign w_lock_ok      = 1'b1;
`endif

  assign w_any_req   = |HBUSREQ;
  assign w_arb_ok    = HREADY && w_lock_ok && (HTRANS != c_trans_busy) &&
                       ((HTRANS == c_trans_idle) || (w_cnt_next <= 4'd1));
  assign w_lock_take = w_arb_ok && w_owner_lock;

  // Round-robin scan starting after the last winner; parks when nobody asks.
  always_comb begin : p_winner
    w_found     = 1'b0;
    w_scan      = c_default_idx;
    w_winner    = c_default_idx;
    w_winner_oh = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_scan = IDX_W'((int'(r_rr_ptr) + k) % NUM_MASTERS);
      if (!w_found && HBUSREQ[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
    end
    w_winner_oh[w_winner] = 1'b1;
  end

  always_ff @(posedge HCLK) begin : p_state_reg
    if (HRESET) r_state <= c_st_park;
    else        r_state <= w_state_next;
  end

  always_comb begin : p_next_state
    w_state_next = r_state;
    if (w_arb_ok) begin
      w_state_next = w_any_req ? c_st_own : c_st_park;
`ifdef AHB_ARB_LOCK_EN
      if (w_lock_take) w_state_next = c_st_locked;
`endif
    end else if (HREADY && !w_locked) begin
      if (w_cnt_next > 4'd1)          w_state_next = c_st_burst;
      else if (r_state == c_st_burst) w_state_next = c_st_own;
    end
  end

  always_comb begin : p_state_out
`ifdef AHB_ARB_LOCK_EN
    w_locked = (r_state == c_st_locked);
`else
    w_locked = 1'b0;
`endif
  end

  always_ff @(posedge HCLK) begin : p_datapath
    if (HRESET) begin
      r_cnt        <= 4'd0;
      r_rr_ptr     <= c_default_idx;
      r_owner      <= c_default_idx;
      r_hgrant     <= c_default_grant;
      r_hmaster    <= c_default_idx;
      r_hmaster_dp <= c_default_idx;
      r_hmastlock  <= 1'b0;
    end else if (HREADY) begin
      r_cnt        <= w_cnt_next;
      r_hmaster    <= r_owner;
      r_hmaster_dp <= r_hmaster;
      r_hmastlock  <= w_owner_lock;
      if (w_arb_ok && !w_lock_take) begin
        r_owner  <= w_winner;
        r_hgrant <= w_winner_oh;
        if (w_winner != r_owner) r_rr_ptr <= w_winner;
      end
    end
  end

  assign HGRANT     = r_hgrant;
  assign HMASTER    = r_hmaster;
  assign HMASTER_DP = r_hmaster_dp;
  assign HMASTLOCK  = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_bus_arbiter
// Brief   : Directed self-checking bench for ahb_bus_arbiter.
// Revision: 1.0
// ============================================================================
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_DP;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .IDX_W         (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_DP(HMASTER_DP),
    .HMASTLOCK (HMASTLOCK)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    HRESET  = 1'b1;
    HBUSREQ = 4'b0000;
    HLOCK   = 4'b0000;
    HTRANS  = IDLE;
    HBURST  = 3'd0;
    HREADY  = 1'b1;
    tick();
    tick();
    HRESET  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and parking
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_grant",  HGRANT,     4'b0001);
      chk("rst_hm",     HMASTER,    2'd0);
      chk("rst_hmdp",   HMASTER_DP, 2'd0);
      chk("rst_lock",   HMASTLOCK,  1'b0);
    end
    chk("rst_cnt", dut.r_cnt, 4'd0);

    // M1 and M2 alternate on SINGLE transfers
    HBUSREQ = 4'b0110;
    tick(); chk("rr_g0", HGRANT, 4'b0010); chk("rr_hm0", HMASTER, 2'd0);
    tick(); chk("rr_g1", HGRANT, 4'b0100); chk("rr_hm1", HMASTER, 2'd1);
    HTRANS = NONSEQ; HBURST = 3'd0;
    tick(); chk("rr_g2", HGRANT, 4'b0010); chk("rr_hm2", HMASTER, 2'd2); chk("rr_dp2", HMASTER_DP, 2'd1);
    tick(); chk("rr_g3", HGRANT, 4'b0100); chk("rr_hm3", HMASTER, 2'd1); chk("rr_dp3", HMASTER_DP, 2'd2);
    HBUSREQ = 4'b0000; HTRANS = IDLE;
    tick(); chk("park_g", HGRANT, 4'b0001);

    // INCR4 by M1 with M2 requesting from the first beat
    do_reset();
    HBUSREQ = 4'b0010;
    tick(); chk("i4_g0", HGRANT, 4'b0010);
    tick(); chk("i4_hm1", HMASTER, 2'd1);
    HBUSREQ = 4'b0110; HTRANS = NONSEQ; HBURST = 3'd3;
    tick(); chk("i4_g_b1", HGRANT, 4'b0010); chk("i4_cnt_b1", dut.r_cnt, 4'd3);
    HTRANS = SEQ;
    tick(); chk("i4_g_b2", HGRANT, 4'b0010); chk("i4_cnt_b2", dut.r_cnt, 4'd2);
    tick(); chk("i4_g_b3", HGRANT, 4'b0100); chk("i4_hm_b3", HMASTER, 2'd1);
    HBUSREQ = 4'b0100;
    tick(); chk("i4_hm_b4", HMASTER, 2'd2); chk("i4_dp_b4", HMASTER_DP, 2'd1); chk("i4_cnt_b4", dut.r_cnt, 4'd0);

    // WRAP8 by M2 with a 3-cycle stall, M1 waiting
    HBUSREQ = 4'b0110; HTRANS = NONSEQ; HBURST = 3'd4;
    tick(); chk("w8_cnt0", dut.r_cnt, 4'd7); chk("w8_g0", HGRANT, 4'b0100);
    HTRANS = SEQ;
    tick(); chk("w8_cnt1", dut.r_cnt, 4'd6);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w8_stall_cnt", dut.r_cnt,  4'd6);
      chk("w8_stall_g",   HGRANT,     4'b0100);
      chk("w8_stall_hm",  HMASTER,    2'd2);
      chk("w8_stall_dp",  HMASTER_DP, 2'd2);
    end
    HREADY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("w8_cnt_b6", dut.r_cnt, 4'd2); chk("w8_g_b6", HGRANT, 4'b0100);
    tick(); chk("w8_g_b7", HGRANT, 4'b0010); chk("w8_hm_b7", HMASTER, 2'd2); chk("w8_cnt_b7", dut.r_cnt, 4'd1);
    HBUSREQ = 4'b0010;
    tick(); chk("w8_hm_b8", HMASTER, 2'd1); chk("w8_g_b8", HGRANT, 4'b0010); chk("w8_cnt_b8", dut.r_cnt, 4'd0);

    // Reset during the second beat of an INCR16 by M2
    do_reset();
    HBUSREQ = 4'b0100;
    tick(); chk("r16_g0", HGRANT, 4'b0100);
    tick(); chk("r16_hm1", HMASTER, 2'd2);
    HTRANS = NONSEQ; HBURST = 3'd7;
    tick(); chk("r16_cnt", dut.r_cnt, 4'd15);
    HTRANS = SEQ; HRESET = 1'b1;
    tick();
    chk("r16_rst_g",    HGRANT,    4'b0001);
    chk("r16_rst_cnt",  dut.r_cnt, 4'd0);
    chk("r16_rst_hm",   HMASTER,   2'd0);
    chk("r16_rst_lock", HMASTLOCK, 1'b0);
    HRESET = 1'b0; HTRANS = IDLE; HBURST = 3'd0;
    tick(); chk("r16_regrant", HGRANT, 4'b0100);
    tick(); chk("r16_hm", HMASTER, 2'd2);

`ifdef AHB_ARB_LOCK_EN
    // M3 locks two SINGLE transfers while M0 requests
    do_reset();
    HBUSREQ = 4'b1001; HLOCK = 4'b1000;
    tick(); chk("lk_g0", HGRANT, 4'b1000); chk("lk_ml0", HMASTLOCK, 1'b0);
    tick(); chk("lk_g1", HGRANT, 4'b1000); chk("lk_hm1", HMASTER, 2'd3); chk("lk_ml1", HMASTLOCK, 1'b1);
    HTRANS = NONSEQ; HBURST = 3'd0;
    tick(); chk("lk_g2", HGRANT, 4'b1000); chk("lk_ml2", HMASTLOCK, 1'b1);
    tick(); chk("lk_g3", HGRANT, 4'b1000); chk("lk_ml3", HMASTLOCK, 1'b1);
    HTRANS = IDLE; HLOCK = 4'b0000; HBUSREQ = 4'b0001;
    tick(); chk("lk_g4", HGRANT, 4'b0001); chk("lk_ml4", HMASTLOCK, 1'b0);
    tick(); chk("lk_hm5", HMASTER, 2'd0);
`else
    // HLOCK has no effect in this build
    do_reset();
    HBUSREQ = 4'b1001; HLOCK = 4'b1000;
    tick(); chk("nl_g0", HGRANT, 4'b1000);
    tick(); chk("nl_g1", HGRANT, 4'b0001); chk("nl_ml1", HMASTLOCK, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
